truth_table_sweeper: RTL and testbench



---
 rtl/truth_table_sweeper.sv | 118 +++++++++++
 tb/tb_truth_table_sweeper.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive-stimulus sequencer: walks all 2^N vectors in binary or Gray order for
// PASSES sweeps, holding each vector HOLD cycles before offering it over valid/ready.
module truth_table_sweeper #(
    parameter int unsigned N      = 3,
    parameter int unsigned PASSES = 2,
    parameter int unsigned HOLD   = 10,
    localparam int unsigned PW    = (PASSES > 1) ? $clog2(PASSES) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          mode,
    input  logic          abort,
    output logic [N-1:0]  vec_out,
    output logic          vec_valid,
    input  logic          vec_ready,
    output logic          last,
    output logic [PW-1:0] pass_idx,
    output logic          busy,
    output logic          done
);

    localparam int unsigned HW = $clog2(HOLD + 1);

    localparam logic [N-1:0]  IdxMax   = {N{1'b1}};
    localparam logic [PW-1:0] PassMax  = PW'(PASSES - 1);
    localparam logic [HW-1:0] HoldLoad = HW'(HOLD);

    typedef enum logic [1:0] {StIdle, StSettle, StSample, StDone} state_e;

    state_e        state_q, state_d;
    logic [N-1:0]  idx_q, idx_d;
    logic [PW-1:0] pass_q, pass_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          mode_q, mode_d;
    logic          final_vec;

    assign final_vec = (idx_q == IdxMax) && (pass_q == PassMax);

    // State register; async reset returns every output to zero immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            idx_q   <= '0;
            pass_q  <= '0;
            hold_q  <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            hold_q  <= hold_d;
            mode_q  <= mode_d;
        end
    end

    // Next-state: settle countdown, handshake advance with pass wrap, abort override.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        hold_d  = hold_q;
        mode_d  = mode_q;
        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    idx_d   = '0;
                    pass_d  = '0;
                    mode_d  = mode;
                    hold_d  = HoldLoad;
                    state_d = StSettle;
                end
            end
            StSettle: begin
                // hold_q == 1 marks the HOLD-th settle cycle
                if (hold_q == HW'(1)) begin
                    state_d = StSample;
                end else begin
                    hold_d = hold_q - HW'(1);
                end
            end
            StSample: begin
                if (vec_ready) begin
                    if (final_vec) begin
                        state_d = StDone;
                    end else begin
                        idx_d   = idx_q + N'(1);
                        if (idx_q == IdxMax) begin
                            pass_d = pass_q + PW'(1);
                        end
                        hold_d  = HoldLoad;
                        state_d = StSettle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
        // abort beats start and any in-flight handshake
        if (abort) begin
            state_d = StIdle;
            idx_d   = '0;
            pass_d  = '0;
            hold_d  = '0;
            mode_d  = 1'b0;
        end
    end

    // Outputs decoded from registered state; vec_out only moves when idx_q or mode_q does.
    always_comb begin
        vec_out   = mode_q ? (idx_q ^ (idx_q >> 1)) : idx_q;
        vec_valid = (state_q == StSample);
        busy      = (state_q == StSettle) || (state_q == StSample);
        done      = (state_q == StDone);
        last      = (state_q == StSample) && final_vec;
        pass_idx  = pass_q;
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomised self-checking bench for truth_table_sweeper against a queue-based sweep model.
module tb_truth_table_sweeper;

    localparam int unsigned N      = 3;
    localparam int unsigned PASSES = 2;
    localparam int unsigned HOLD   = 10;
    localparam int unsigned PW     = (PASSES > 1) ? $clog2(PASSES) : 1;
    localparam int          VECS   = 1 << N;
    localparam int          TOTAL  = PASSES * VECS * (HOLD + 1);
    localparam int          BUDGET = 20000;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          mode = 1'b0;
    logic          abort = 1'b0;
    logic          vec_ready = 1'b0;
    logic [N-1:0]  vec_out;
    logic          vec_valid;
    logic          last;
    logic [PW-1:0] pass_idx;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    truth_table_sweeper #(.N(N), .PASSES(PASSES), .HOLD(HOLD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .mode      (mode),
        .abort     (abort),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .last      (last),
        .pass_idx  (pass_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // One run against the model: expected order is every index of every pass,
    // mapped through the requested ordering. Checks happen at negedges.
    task automatic sweep(input logic m, input bit rnd_ready, input bit noise, input bit bp3,
                         input int abort_at, input bit timing, input string tag);
        logic [N-1:0] q_vec[$];
        int           q_pass[$];
        int           q_idx[$];
        logic [N-1:0] last_hs_vec = '0;
        bit           have_hs = 0;
        bit           prev_hs = 0;
        bit           finished = 0;
        bit           hs;
        int           bp_cnt = 0;
        int           cyc = 0;
        for (int p = 0; p < PASSES; p++) begin
            for (int i = 0; i < VECS; i++) begin
                q_vec.push_back(m ? N'(i ^ (i >> 1)) : N'(i));
                q_pass.push_back(p);
                q_idx.push_back(i);
            end
        end
        @(negedge clk);
        mode = m; start = 1'b1; abort = 1'b0; vec_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        while (!finished && cyc <= BUDGET) begin
            if (done === 1'b1) begin
                finished = 1; start = 1'b0;
                checks++;
                if (q_vec.size() != 0) begin
                    errors++;
                    $display("FAIL %s done_early: got %0d vectors left required 0", tag, q_vec.size());
                end
                if (timing) begin
                    checks++;
                    if (cyc != TOTAL) begin
                        errors++;
                        $display("FAIL %s done_latency: got %0d cycles required %0d", tag, cyc, TOTAL);
                    end
                end
                checks++;
                if (busy !== 1'b0 || vec_valid !== 1'b0 || last !== 1'b0) begin
                    errors++;
                    $display("FAIL %s done_outputs: got busy=%b valid=%b last=%b required 0 0 0",
                             tag, busy, vec_valid, last);
                end
            end else if (q_vec.size() == 0) begin
                finished = 1;
                checks++; errors++;
                $display("FAIL %s done_missing: got done=%b required 1", tag, done);
            end else begin
                checks++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    errors++;
                    $display("FAIL %s run_flags: got busy=%b done=%b required 1 0", tag, busy, done);
                end
                checks++;
                if (vec_out !== q_vec[0]) begin
                    errors++;
                    $display("FAIL %s vec_out: got %0d required %0d (pass %0d idx %0d cyc %0d)",
                             tag, vec_out, q_vec[0], q_pass[0], q_idx[0], cyc);
                end
                checks++;
                if (pass_idx !== PW'(q_pass[0])) begin
                    errors++;
                    $display("FAIL %s pass_idx: got %0d required %0d", tag, pass_idx, q_pass[0]);
                end
                checks++;
                if (last !== (vec_valid === 1'b1 && q_vec.size() == 1)) begin
                    errors++;
                    $display("FAIL %s last: got %b required %b", tag, last,
                             (vec_valid === 1'b1 && q_vec.size() == 1));
                end
                if (prev_hs) begin
                    checks++;
                    if (vec_valid !== 1'b0) begin
                        errors++;
                        $display("FAIL %s valid_drop: got %b required 0", tag, vec_valid);
                    end
                end
                if (timing) begin
                    checks++;
                    if (vec_valid !== ((cyc % (HOLD + 1)) == HOLD)) begin
                        errors++;
                        $display("FAIL %s valid_timing: got %b required %b at cyc %0d", tag,
                                 vec_valid, ((cyc % (HOLD + 1)) == HOLD), cyc);
                    end
                end
                if (abort_at >= 0 && q_pass[0] == 0 && q_idx[0] == abort_at && vec_valid === 1'b0) begin
                    abort = 1'b1;
                    @(negedge clk);
                    abort = 1'b0;
                    finished = 1;
                    checks++;
                    if (busy !== 1'b0 || done !== 1'b0 || vec_out !== '0 || vec_valid !== 1'b0 ||
                        last !== 1'b0 || pass_idx !== '0) begin
                        errors++;
                        $display("FAIL %s abort_state: got busy=%b done=%b vec=%0d valid=%b last=%b pass=%0d required all 0",
                                 tag, busy, done, vec_out, vec_valid, last, pass_idx);
                    end
                end else begin
                    if (bp3 && q_pass[0] == 0 && q_idx[0] == 3 && vec_valid === 1'b1 && bp_cnt < 5) begin
                        vec_ready = 1'b0;
                        bp_cnt++;
                        checks++;
                        if (vec_out !== N'(3)) begin
                            errors++;
                            $display("FAIL %s bp_hold: got %0d required 3", tag, vec_out);
                        end
                    end else begin
                        vec_ready = rnd_ready ? ($urandom_range(0, 2) != 0) : 1'b1;
                    end
                    if (noise) begin
                        start = ($urandom_range(0, 7) == 0);
                        mode  = 1'($urandom_range(0, 1));
                    end
                    hs = (vec_valid === 1'b1) && vec_ready;
                    if (hs) begin
                        if (m && have_hs) begin
                            checks++;
                            if ($countones(vec_out ^ last_hs_vec) != 1) begin
                                errors++;
                                $display("FAIL %s gray_step: got %0d after %0d required one-bit change",
                                         tag, vec_out, last_hs_vec);
                            end
                        end
                        last_hs_vec = vec_out;
                        have_hs = 1;
                        void'(q_vec.pop_front());
                        void'(q_pass.pop_front());
                        void'(q_idx.pop_front());
                    end
                    prev_hs = hs;
                    @(negedge clk);
                    cyc++;
                end
            end
        end
        start = 1'b0;
        vec_ready = 1'b0;
        if (!finished) begin
            checks++; errors++;
            $display("FAIL %s timeout: got no completion required done within %0d cycles", tag, BUDGET);
        end
        if (bp3) begin
            checks++;
            if (bp_cnt != 5) begin
                errors++;
                $display("FAIL %s bp_cycles: got %0d stalled cycles required 5", tag, bp_cnt);
            end
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (vec_out !== '0 || vec_valid !== 1'b0 || last !== 1'b0 || pass_idx !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset: got vec=%0d valid=%b last=%b pass=%0d busy=%b done=%b required all 0",
                     vec_out, vec_valid, last, pass_idx, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_binary();
        sweep(1'b0, 0, 0, 0, -1, 1, "binary");
        repeat (5) @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL done_sticky: got done=%b busy=%b required 1 0", done, busy);
        end
    endtask

    // Starting again from DONE must clear done and replay the full sweep.
    task automatic test_gray();
        sweep(1'b1, 0, 0, 0, -1, 1, "gray");
    endtask

    task automatic test_backpressure();
        sweep(1'b0, 0, 0, 1, -1, 0, "backpressure");
    endtask

    task automatic test_abort();
        sweep(1'b0, 0, 0, 0, 5, 0, "abort");
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || vec_out !== '0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b done=%b vec=%0d required 0 0 0", busy, done, vec_out);
        end
        sweep(1'b1, 0, 0, 0, -1, 1, "after_abort");
    endtask

    // Random backpressure plus stray start pulses and mode toggles mid-run.
    task automatic test_random_noise();
        for (int r = 0; r < 4; r++) begin
            sweep(1'($urandom_range(0, 1)), 1, 1, 0, -1, 0, "random");
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        mode = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got busy=%b required 1", busy);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (vec_out !== '0 || vec_valid !== 1'b0 || last !== 1'b0 || pass_idx !== '0 ||
            busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: got vec=%0d valid=%b busy=%b done=%b required all 0",
                     vec_out, vec_valid, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || vec_valid !== 1'b0 || done !== 1'b0 || vec_out !== '0) begin
            errors++;
            $display("FAIL async_idle: got busy=%b valid=%b done=%b vec=%0d required 0 0 0 0",
                     busy, vec_valid, done, vec_out);
        end
    endtask

    initial begin
        test_reset();
        test_binary();
        test_gray();
        test_backpressure();
        test_abort();
        test_random_noise();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
